// File: rtl/spi_slave_rx_lanes_pkg.sv
// Shared types and constants for the SPI slave receive datapath.
package spi_slave_pkg;

   typedef enum logic [1:0] {
      OFF,
      RX,
      WAIT
   } rx_state_e;

   localparam logic LANES_SINGLE = 1'b0;
   localparam logic LANES_QUAD   = 1'b1;

   localparam int DEFAULT_CMD_BITS = 8;

endpackage

// File: rtl/spi_slave_rx_shifter.sv
// MSB-first deserialising shift register with clear and 1- or 4-lane shift-in.
// The output is the value the register takes on the coming edge, so the
// caller can capture a word together with the bits of its final edge.
module spi_slave_rx_shifter
   import spi_slave_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             clr,
   input  logic             quad,
   input  logic [3:0]       sdi,
   output logic [WIDTH-1:0] word
);

   logic [WIDTH-1:0] value;
   logic [WIDTH-1:0] base;

   // Next shift value: start from zero at a word start, then append the lane bits.
   always_comb begin
      base = clr ? '0 : value;
      if (quad == LANES_QUAD) begin
         word = {base[WIDTH-5:0], sdi};
      end else begin
         word = {base[WIDTH-2:0], sdi[0]};
      end
   end

   // Shift register update; holds while not enabled.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         value <= '0;
      end else if (en) begin
         value <= word;
      end
   end

endmodule

// File: rtl/spi_slave_rx_lanes.sv
// SPI slave receive datapath: single/quad-lane deserialiser with programmable
// word length, registered word output and a one-cycle ready strobe.
module spi_slave_rx_lanes
   import spi_slave_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8,
   parameter int CMD_BITS   = DEFAULT_CMD_BITS
) (
   input  logic                  sclk,
   input  logic                  rstn,
   input  logic                  cs,
   input  logic [3:0]            sdi,
   input  logic                  quad_en,
   input  logic [CNT_WIDTH-1:0]  counter_in,
   input  logic                  counter_in_upd,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  data_ready
);

   localparam logic [CNT_WIDTH:0]   DW_EXT     = (CNT_WIDTH+1)'(DATA_WIDTH);
   localparam logic [CNT_WIDTH-1:0] MAX_TARGET = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CMD_TARGET = CNT_WIDTH'(CMD_BITS - 1);

   rx_state_e             state, state_next;
   logic [CNT_WIDTH-1:0]  count, count_next;
   logic [CNT_WIDTH-1:0]  target, target_next;
   logic                  quad, quad_next;
   logic [DATA_WIDTH-1:0] data_next;
   logic                  ready_next;

   logic [CNT_WIDTH-1:0]  cur_target;
   logic [CNT_WIDTH-1:0]  cur_count;
   logic                  cur_quad;
   logic [CNT_WIDTH:0]    step;
   logic [CNT_WIDTH:0]    sum;
   logic                  done;
   logic [CNT_WIDTH-1:0]  upd_target;

   logic                  shift_en;
   logic                  shift_clr;
   logic                  shift_quad;
   logic [DATA_WIDTH-1:0] shift_word;

   // Saturate the requested length to the word width; quad words round up to whole nibbles.
   function automatic logic [CNT_WIDTH-1:0] eff_target(input logic [CNT_WIDTH-1:0] len,
                                                       input logic               q);
      logic [CNT_WIDTH-1:0] t;
      t = ({1'b0, len} >= DW_EXT) ? MAX_TARGET : len;
      if (q == LANES_QUAD) begin
         t[1:0] = 2'b11;
      end
      return t;
   endfunction

   assign upd_target = eff_target(counter_in, quad_en);

   spi_slave_rx_shifter #(
      .WIDTH(DATA_WIDTH)
   ) u_shifter (
      .clk  (sclk),
      .rstn (rstn),
      .en   (shift_en),
      .clr  (shift_clr),
      .quad (shift_quad),
      .sdi  (sdi),
      .word (shift_word)
   );

   // Next-state logic: frame control, word length tracking and word capture.
   always_comb begin
      state_next  = state;
      count_next  = count;
      target_next = target;
      quad_next   = quad;
      data_next   = data;
      ready_next  = 1'b0;
      shift_en    = 1'b0;
      shift_clr   = 1'b0;

      cur_target = target;
      cur_quad   = quad;
      cur_count  = count;
      if (state == OFF) begin
         cur_target = CMD_TARGET;
         cur_quad   = LANES_SINGLE;
         cur_count  = '0;
      end
      shift_quad = cur_quad;
      step       = (cur_quad == LANES_QUAD) ? (CNT_WIDTH+1)'(4) : (CNT_WIDTH+1)'(1);
      sum        = {1'b0, cur_count} + step;
      done       = sum > {1'b0, cur_target};

      if (cs) begin
         state_next  = OFF;
         count_next  = '0;
         target_next = CMD_TARGET;
         quad_next   = LANES_SINGLE;
      end else begin
         case (state)
            OFF, RX: begin
               shift_en    = 1'b1;
               shift_clr   = (cur_count == '0);
               target_next = cur_target;
               quad_next   = cur_quad;
               if (done) begin
                  data_next  = shift_word;
                  ready_next = 1'b1;
                  count_next = '0;
                  if (counter_in_upd && state == RX) begin
                     target_next = upd_target;
                     quad_next   = quad_en;
                     state_next  = RX;
                  end else begin
                     state_next = WAIT;
                  end
               end else begin
                  count_next = sum[CNT_WIDTH-1:0];
                  state_next = RX;
                  if (counter_in_upd && state == RX) begin
                     target_next = upd_target;
                     quad_next   = quad_en;
                  end
               end
            end
            WAIT: begin
               if (counter_in_upd) begin
                  target_next = upd_target;
                  quad_next   = quad_en;
                  count_next  = '0;
                  state_next  = RX;
               end
            end
            default: begin
               state_next = OFF;
            end
         endcase
      end
   end

   // State, length and output registers with synchronous active-low reset.
   always_ff @(posedge sclk) begin
      if (!rstn) begin
         state      <= OFF;
         count      <= '0;
         target     <= CMD_TARGET;
         quad       <= LANES_SINGLE;
         data       <= '0;
         data_ready <= 1'b0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         target     <= target_next;
         quad       <= quad_next;
         data       <= data_next;
         data_ready <= ready_next;
      end
   end

endmodule

// File: tb/tb_spi_slave_rx_lanes.sv
// Self-checking bench for spi_slave_rx_lanes: directed scenarios followed by
// random traffic, all compared against a word-level reference model.
module tb_spi_slave_rx_lanes;

   logic        sclk;
   logic        rstn;
   logic        cs;
   logic [3:0]  sdi;
   logic        quad_en;
   logic [7:0]  counter_in;
   logic        counter_in_upd;
   logic [31:0] data;
   logic        data_ready;

   int vec_count  = 0;
   int miscompares = 0;

   // Reference model: frame phase (0 idle, 1 receiving, 2 waiting), word length in bits
   int          m_phase = 0;
   int          m_bits  = 0;
   int          m_len   = 8;
   bit          m_quad  = 0;
   logic [63:0] m_acc   = '0;
   logic [31:0] m_data  = '0;
   bit          m_ready = 0;

   spi_slave_rx_lanes #(
      .DATA_WIDTH(32),
      .CNT_WIDTH (8),
      .CMD_BITS  (8)
   ) dut (
      .sclk          (sclk),
      .rstn          (rstn),
      .cs            (cs),
      .sdi           (sdi),
      .quad_en       (quad_en),
      .counter_in    (counter_in),
      .counter_in_upd(counter_in_upd),
      .data          (data),
      .data_ready    (data_ready)
   );

   // Free-running SPI clock.
   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_count++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int calcLen(input logic [7:0] c, input bit q);
      int l;
      l = int'(c) + 1;
      if (l > 32) l = 32;
      if (q) l = ((l + 3) / 4) * 4;
      return l;
   endfunction

   task automatic modelStep(input bit r, input bit c, input logic [3:0] s,
                            input bit u, input bit q, input logic [7:0] n);
      bit was_rx;
      m_ready = 0;
      if (!r) begin
         m_phase = 0; m_bits = 0; m_len = 8; m_quad = 0; m_data = '0;
      end else if (c) begin
         m_phase = 0; m_bits = 0; m_len = 8; m_quad = 0;
      end else if (m_phase == 2) begin
         if (u) begin
            m_len = calcLen(n, q); m_quad = q; m_bits = 0; m_phase = 1;
         end
      end else begin
         was_rx = (m_phase == 1);
         if (!was_rx) begin
            m_len = 8; m_quad = 0; m_bits = 0;
         end
         if (m_bits == 0) m_acc = '0;
         if (m_quad) begin
            m_acc  = m_acc * 16 + 64'(s);
            m_bits = m_bits + 4;
         end else begin
            m_acc  = m_acc * 2 + 64'(s[0]);
            m_bits = m_bits + 1;
         end
         if (m_bits >= m_len) begin
            m_data  = m_acc[31:0];
            m_ready = 1;
            m_bits  = 0;
            if (u && was_rx) begin
               m_len = calcLen(n, q); m_quad = q; m_phase = 1;
            end else begin
               m_phase = 2;
            end
         end else begin
            m_phase = 1;
            if (u && was_rx) begin
               m_len = calcLen(n, q); m_quad = q;
            end
         end
      end
   endtask

   // One sclk edge: drive inputs, advance the model, check both outputs after the edge.
   task automatic applyStimulus(input bit r, input bit c, input logic [3:0] s,
                                input bit u, input bit q, input logic [7:0] n);
      rstn = r; cs = c; sdi = s; counter_in_upd = u; quad_en = q; counter_in = n;
      @(posedge sclk);
      modelStep(r, c, s, u, q, n);
      #1;
      checkOutput("data", data, m_data);
      checkOutput("data_ready", {31'b0, data_ready}, {31'b0, m_ready});
      @(negedge sclk);
   endtask

   // Send a word MSB-first; the length update rides on the final edge when requested.
   task automatic sendWord(input logic [31:0] w, input int nbits, input bit qm,
                           input bit last_upd, input bit nq, input logic [7:0] nc);
      int edges;
      int idx;
      logic [3:0] s;
      edges = qm ? nbits / 4 : nbits;
      for (int i = 0; i < edges; i++) begin
         if (qm) begin
            idx = nbits - 1 - 4 * i;
            s   = w[idx -: 4];
         end else begin
            s = {3'($urandom_range(0, 7)), w[nbits - 1 - i]};
         end
         applyStimulus(1, 0, s, (i == edges - 1) ? last_upd : 1'b0, nq, nc);
      end
   endtask

   initial begin
      logic [10:0] mid_bits;
      rstn = 0; cs = 1; sdi = '0; quad_en = 0; counter_in = '0; counter_in_upd = 0;
      @(negedge sclk);

      repeat (3) applyStimulus(0, 1, 4'h0, 0, 0, 8'h00);
      checkOutput("reset_data", data, 32'h0);
      checkOutput("reset_ready", {31'b0, data_ready}, 32'h0);
      applyStimulus(1, 1, 4'hF, 1, 0, 8'h10);

      $display("[TB] command word, then 32-bit single word back to back");
      sendWord(32'h000000A5, 8, 0, 1, 0, 8'd31);
      checkOutput("cmd_a5", data, 32'h000000A5);
      checkOutput("cmd_a5_ready", {31'b0, data_ready}, 32'h1);
      sendWord(32'hDEADBEEF, 32, 0, 1, 1, 8'd15);
      checkOutput("deadbeef", data, 32'hDEADBEEF);

      $display("[TB] quad 16-bit word, then idle in wait");
      sendWord(32'h00001234, 16, 1, 0, 0, 8'd0);
      checkOutput("quad_1234", data, 32'h00001234);
      repeat (5) applyStimulus(1, 0, 4'($urandom), 0, 0, 8'd7);
      checkOutput("wait_hold", data, 32'h00001234);
      checkOutput("wait_no_ready", {31'b0, data_ready}, 32'h0);

      $display("[TB] resume with quad length 13");
      applyStimulus(1, 0, 4'h9, 1, 1, 8'd13);
      sendWord(32'h0000ABCD, 16, 1, 0, 0, 8'd0);
      checkOutput("quad_len13", data, 32'h0000ABCD);

      $display("[TB] chip select drops mid-word");
      applyStimulus(1, 0, 4'h0, 1, 0, 8'd31);
      for (int i = 0; i < 20; i++) applyStimulus(1, 0, 4'($urandom), 0, 0, 8'd0);
      applyStimulus(1, 1, 4'h1, 0, 0, 8'd0);
      checkOutput("cs_abort_hold", data, 32'h0000ABCD);
      checkOutput("cs_abort_ready", {31'b0, data_ready}, 32'h0);

      $display("[TB] restart with command word and saturated length");
      sendWord(32'h0000003C, 8, 0, 1, 0, 8'hFF);
      checkOutput("restart_cmd", data, 32'h0000003C);
      sendWord(32'h12345678, 32, 0, 1, 0, 8'd31);
      checkOutput("sat_len", data, 32'h12345678);

      $display("[TB] shortened length mid-word");
      mid_bits = 11'b101_1001_1101;
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1, 0, {3'b000, mid_bits[10 - i]}, (i == 9) ? 1'b1 : 1'b0, 0, 8'd3);
      end
      checkOutput("short_mid", data, 32'h0000059D);
      checkOutput("short_mid_ready", {31'b0, data_ready}, 32'h1);

      $display("[TB] reset mid-word");
      applyStimulus(1, 0, 4'h0, 1, 0, 8'd31);
      repeat (5) applyStimulus(1, 0, 4'($urandom), 0, 0, 8'd0);
      applyStimulus(0, 0, 4'hF, 1, 1, 8'd3);
      checkOutput("rst_mid_data", data, 32'h0);
      checkOutput("rst_mid_ready", {31'b0, data_ready}, 32'h0);

      $display("[TB] random traffic");
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 99) != 0,
                       $urandom_range(0, 39) == 0,
                       4'($urandom),
                       $urandom_range(0, 4) == 0,
                       1'($urandom),
                       ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 40)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
